// File: rtl/result_bcd_display.sv
// Captures divider quotient/remainder on a load edge, converts both to BCD with
// double-dabble engines, and scans them onto a 6-digit active-low 7-segment display.
`timescale 1ns/1ps
module result_bcd_display #(
    parameter int unsigned SCAN_DIV = 16667
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [6:0]  Q_in,
    input  logic [6:0]  R_in,
    output logic        busy,
    output logic        valid,
    output logic [11:0] bcd_q,
    output logic [11:0] bcd_r,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e      state_q, state_d;
    logic        load_q;
    logic [2:0]  iter_q, iter_d;
    logic [6:0]  qbin_q, qbin_d, rbin_q, rbin_d;
    logic [11:0] qacc_q, qacc_d, racc_q, racc_d;
    logic [11:0] qadj, radj;
    logic        commit;
    logic        blank_all_q;
    logic [CntW-1:0] scan_cnt_q;
    logic [2:0]  idx_q;
    logic [3:0]  digit;
    logic        blank;

    function automatic logic [11:0] add3(input logic [11:0] a);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = (a[4*i +: 4] >= 4'd5) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign qadj = add3(qacc_q);
    assign radj = add3(racc_q);
    assign busy = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        qbin_d  = qbin_q;
        rbin_d  = rbin_q;
        qacc_d  = qacc_q;
        racc_d  = racc_q;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (load && !load_q) begin
                    qbin_d  = Q_in;
                    rbin_d  = R_in;
                    qacc_d  = '0;
                    racc_d  = '0;
                    iter_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                qacc_d = {qadj[10:0], qbin_q[6]};
                racc_d = {radj[10:0], rbin_q[6]};
                qbin_d = {qbin_q[5:0], 1'b0};
                rbin_d = {rbin_q[5:0], 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd6) state_d = StCommit;
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            load_q      <= 1'b0;
            iter_q      <= '0;
            qbin_q      <= '0;
            rbin_q      <= '0;
            qacc_q      <= '0;
            racc_q      <= '0;
            valid       <= 1'b0;
            bcd_q       <= '0;
            bcd_r       <= '0;
            blank_all_q <= 1'b1;
        end else begin
            state_q <= state_d;
            load_q  <= load;
            iter_q  <= iter_d;
            qbin_q  <= qbin_d;
            rbin_q  <= rbin_d;
            qacc_q  <= qacc_d;
            racc_q  <= racc_d;
            valid   <= commit;
            if (commit) begin
                bcd_q       <= qacc_q;
                bcd_r       <= racc_q;
                blank_all_q <= 1'b0;
            end
        end
    end

    // Free-running digit scan, independent of the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else if (scan_cnt_q == CntMax) begin
            scan_cnt_q <= '0;
            idx_q      <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + CntW'(1);
        end
    end

    always_comb begin
        digit = 4'h0;
        blank = 1'b1;
        case (idx_q)
            3'd5: begin digit = bcd_q[11:8]; blank = (bcd_q[11:8] == 4'd0); end
            3'd4: begin digit = bcd_q[7:4];  blank = (bcd_q[11:4] == 8'd0); end
            3'd3: begin digit = bcd_q[3:0];  blank = 1'b0; end
            3'd2: begin digit = bcd_r[11:8]; blank = (bcd_r[11:8] == 4'd0); end
            3'd1: begin digit = bcd_r[7:4];  blank = (bcd_r[11:4] == 8'd0); end
            3'd0: begin digit = bcd_r[3:0];  blank = 1'b0; end
            default: blank = 1'b1;
        endcase
        if (blank_all_q) blank = 1'b1;
        an  = blank ? 6'b111111 : ~(6'b000001 << idx_q);
        seg = blank ? 7'b1111111 : hex7(digit);
        dp  = !((idx_q == 3'd3) && !blank_all_q);
    end

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: reset state, conversion timing, load
// edge handling, busy-drop, mid-conversion reset and one scan frame per result.
`timescale 1ns/1ps
module tb_result_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [6:0]  Q_in = '0;
    logic [6:0]  R_in = '0;
    logic        busy, valid, dp;
    logic [11:0] bcd_q, bcd_r;
    logic [5:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    result_bcd_display #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .Q_in  (Q_in),
        .R_in  (R_in),
        .busy  (busy),
        .valid (valid),
        .bcd_q (bcd_q),
        .bcd_r (bcd_r),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_blank_idle(input string tag);
        check(tag, 32'({busy, valid, dp, an, seg}), 32'({1'b0, 1'b0, 1'b1, 6'h3f, 7'h7f}));
    endtask

    // Load held for `hold` cycles starting at the accepting edge k.
    task automatic convert(input int q, input int r, input int hold);
        int last;
        tick();
        Q_in = 7'(q);
        R_in = 7'(r);
        load = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j + 1 >= hold) load = 1'b0;
            check("busy_during", 32'(busy), 32'd1);
            check("valid_early", 32'(valid), 32'd0);
        end
        tick();
        if (9 >= hold) load = 1'b0;
        check("busy_after", 32'(busy), 32'd0);
        check("valid_pulse", 32'(valid), 32'd1);
        check("bcd_q", 32'(bcd_q), 32'(to_bcd(q)));
        check("bcd_r", 32'(bcd_r), 32'(to_bcd(r)));
        last = ((hold > 9) ? hold : 9) + 3;
        for (int j = 9; j < last; j++) begin
            tick();
            if (j + 1 >= hold) load = 1'b0;
            check("valid_once", 32'(valid), 32'd0);
        end
        load = 1'b0;
    endtask

    task automatic check_frame(input int q, input int r);
        logic [11:0] bq, br;
        logic [6:0]  exp_seg [6];
        logic [5:0]  exp_mask, seen, lows;
        bq = to_bcd(q);
        br = to_bcd(r);
        exp_seg[5] = seg_of(bq[11:8]);
        exp_seg[4] = seg_of(bq[7:4]);
        exp_seg[3] = seg_of(bq[3:0]);
        exp_seg[2] = seg_of(br[11:8]);
        exp_seg[1] = seg_of(br[7:4]);
        exp_seg[0] = seg_of(br[3:0]);
        exp_mask = {q >= 100, q >= 10, 1'b1, r >= 100, r >= 10, 1'b1};
        seen = '0;
        for (int c = 0; c < 24; c++) begin
            tick();
            lows = ~an;
            seen |= lows;
            check("an_onehot", 32'($countones(lows) <= 1), 32'd1);
            check("dp_on_idx3", 32'(dp), 32'(an[3]));
            for (int p = 0; p < 6; p++) begin
                if (lows[p]) check($sformatf("seg_digit%0d", p), 32'(seg), 32'(exp_seg[p]));
            end
        end
        check("an_frame_mask", 32'(seen), 32'(exp_mask));
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("reset_bcd", 32'({bcd_q, bcd_r}), 32'd0);
        for (int c = 0; c < 30; c++) begin
            tick();
            check_blank_idle("reset_idle");
        end

        convert(3, 1, 1);
        check_frame(3, 1);

        convert(9, 10, 20);
        check_frame(9, 10);

        convert(127, 127, 1);
        check_frame(127, 127);

        // Second rising edge while busy must be dropped.
        tick();
        Q_in = 7'd50;
        R_in = 7'd0;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("busy_k", 32'(busy), 32'd1);
        tick();
        tick();
        Q_in = 7'd99;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("busy_k3", 32'(busy), 32'd1);
        for (int j = 4; j < 8; j++) begin
            tick();
            check("drop_valid_early", 32'(valid), 32'd0);
        end
        tick();
        check("drop_valid", 32'(valid), 32'd1);
        check("drop_bcd_q", 32'(bcd_q), 32'h050);
        check("drop_bcd_r", 32'(bcd_r), 32'h000);
        for (int j = 0; j < 12; j++) begin
            tick();
            check("drop_no_rerun", 32'({busy, valid}), 32'd0);
        end

        // Reset in the middle of a conversion.
        tick();
        Q_in = 7'd77;
        R_in = 7'd3;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        check_blank_idle("abort_async");
        check("abort_bcd", 32'({bcd_q, bcd_r}), 32'd0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            check_blank_idle("abort_idle");
        end

        convert(19, 5, 1);
        check_frame(19, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_bcd_display.md
# result_bcd_display

Downstream stage of the 7-bit restoring divider: on the divider's completion strobe it captures quotient and remainder, converts each to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a 6-digit multiplexed 7-segment display. The upper three digits show Q and the lower three show R, with leading-zero blanking per group and a decimal point separating them. Converted BCD values are also exported for checking and for other consumers.

## Interface

- SCAN_DIV, 16667, clock cycles each digit stays selected; legal range ≥ 2. Benches use 4.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  divider `done`; may be a pulse or a held level; rising edge requests capture
- Q_in  in  7  quotient, 0..127
- R_in  in  7  remainder, 0..127
- busy  out  1  high while a conversion is in progress
- valid  out  1  one-cycle pulse when new digits are committed
- bcd_q  out  12  committed Q as {hundreds, tens, ones}
- bcd_r  out  12  committed R as {hundreds, tens, ones}
- an  out  6  digit enables, active-low; an[5] = Q hundreds … an[0] = R ones
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation

- Capture: a request is `load`=1 while the previous-cycle registered `load` was 0. A request is accepted only in IDLE. On acceptance, Q_in and R_in are latched, the BCD accumulators are cleared, and the state goes to SHIFT. A level held high is captured once. A request while busy is dropped. No queueing.
- FSM:
  - IDLE: accepts a request and moves to SHIFT.
  - SHIFT: 7 iterations with a 3-bit counter. Each iteration applies add-3 to every BCD nibble ≥5, then shifts {bcd, bin} left by 1. Q and R convert in parallel, one engine each.
  - COMMIT: copies the accumulators to bcd_q/bcd_r and the display registers, clears the blank-all flag, pulses valid, and returns to IDLE.
- Width rules: the accumulators are 12 bits. The hundreds nibble is never greater than 1.
- Blanking, per group:
  - Hundreds is blanked if it is 0.
  - Tens is blanked if hundreds and tens are both 0.
  - Ones is never blanked.
  - Before the first commit after reset, all six digits are blanked.
  - A blanked digit keeps its anode high, so the digit is off.
- Scan:
  - A counter runs 0..SCAN_DIV-1.
  - The digit index runs 0..5 and advances when the counter equals SCAN_DIV-1. Index 5 wraps to 0.
  - an = ~(1<<idx), unless the digit is blanked, in which case an is all ones.
  - seg is the hex-to-7-seg decode of the selected digit; 0 → 1000000, 1 → 1111001, …, 9 → 0010000.
  - dp = 0 only when idx=3 and data has been committed.
- Scanning runs continuously and independently of the FSM. The display registers change only in COMMIT.

## Timing

- Reset values (asynchronous):
  - state IDLE, busy=0, valid=0
  - bcd_q=0, bcd_r=0
  - scan counter=0, idx=0
  - all blank, so an=111111, seg=1111111, dp=1
  - registered load=0. A load already high when rst releases therefore counts as a request.
- Latency:
  - Request accepted at edge k.
  - busy is high from after edge k to after edge k+8.
  - SHIFT occupies edges k+1..k+7.
  - COMMIT is at edge k+8: bcd_q, bcd_r and the display update, and valid is high for the cycle after edge k+8.
  - The earliest next acceptance is edge k+9.
- rst asserted mid-conversion: the conversion is aborted, the display blanks, and no valid pulse occurs.
- After a commit, the digits persist until the next commit or reset.
- seg, an and dp are combinational from registered state. There is no extra cycle of latency.

## Test plan

- Reset with SCAN_DIV=4: hold rst, then release. Required: an=111111, seg=1111111, dp=1, busy=0 across 30 cycles.
- Q=3, R=1 with a one-cycle load: busy for 8 cycles, valid at edge k+8, bcd_q=0x003, bcd_r=0x001. Over one scan frame only an[3] and an[0] go low; seg shows 0110000 on idx 3 and 1111001 on idx 0; dp is low on idx 3.
- Q=9, R=10 with load held high for 20 cycles: exactly one valid pulse, bcd_q=0x009, bcd_r=0x010. Digits 5 and 4 are blanked; digit 1 shows 1 and digit 0 shows 0.
- Q=127, R=127: bcd_q=bcd_r=0x127, and all six anodes are exercised in one frame.
- Q=50 converting, then a new rising edge on load at k+3 with Q=99: the second request is ignored and bcd_q=0x050.
- rst pulsed at k+4 during a conversion: no valid pulse, outputs return to reset values. A new load of Q=19, R=5 then gives bcd_q=0x019, bcd_r=0x005.
